// File: rtl/dcache_mem_side_if.sv
// rtl/dcache_mem_side_if.sv - backing-memory request/response channel of the data cache
interface dcache_mem_side_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dcache_mem_side.sv
// rtl/dcache_mem_side.sv - blocking direct-mapped write-through data cache, core data port responder
module dcache_mem_side #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  dcache_mem_side_if.master mem
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WREQ, S_RREQ, S_REFILL} state_t;
  state_t state, state_nxt;

  logic [29:0]      req_waddr;
  logic [31:0]      req_data;
  logic [3:0]       req_mask;
  logic             rd_pend;
  logic             sel_load;
  logic [OFF_W-1:0] beat_cnt;
  logic [31:0]      load_q;
  logic [31:0]      rd_word;
  logic [TAG_W-1:0] tag_q;
  logic [LINES-1:0] valid;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  logic [IDX_W-1:0] in_idx, req_idx;
  logic [OFF_W-1:0] in_off, req_off;
  logic [TAG_W-1:0] req_tag;
  logic             hit, handshake, beat_take, beat_last, sample, take_read, wr_commit;
  logic             unused_addr_bits;

  assign in_idx  = dcache_addr[2+OFF_W +: IDX_W];
  assign in_off  = dcache_addr[2 +: OFF_W];
  assign req_idx = req_waddr[OFF_W +: IDX_W];
  assign req_off = req_waddr[OFF_W-1:0];
  assign req_tag = req_waddr[29 -: TAG_W];
  assign unused_addr_bits = ^dcache_addr[1:0];

  // tag_q was read at the sampling edge, so it describes the line the latched request maps to
  assign hit       = valid[req_idx] && (tag_q == req_tag);
  assign handshake = mem.mem_req_valid && mem.mem_req_ready;
  assign beat_take = (state == S_REFILL) && mem.mem_resp_valid;
  assign beat_last = beat_take && (beat_cnt == LAST_BEAT);
  assign sample    = (state == S_IDLE) && !stall;
  assign take_read = sample && (dcache_we == 4'b0000) && dcache_re;
  assign wr_commit = (state == S_WREQ) && handshake && hit;

  always_comb begin
    state_nxt         = state;
    stall             = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_rw    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_pend && !hit) begin
          stall     = 1'b1;
          state_nxt = S_RREQ;
        end else if (dcache_we != 4'b0000) begin
          state_nxt = S_WREQ;
        end
      end
      S_WREQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_req_rw    = 1'b1;
        if (mem.mem_req_ready) state_nxt = S_IDLE;
      end
      S_RREQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        stall = 1'b1;
        if (beat_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem.mem_req_addr = (state == S_WREQ) ? req_waddr
                                              : {req_waddr[29:OFF_W], {OFF_W{1'b0}}};
  assign mem.mem_req_data = req_data;
  assign mem.mem_req_mask = req_mask;

  // the load register stays selected after a refill until the next read is sampled
  assign dcache_dout = sel_load ? load_q : rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_pend   <= 1'b0;
      sel_load  <= 1'b0;
      valid     <= '0;
      req_waddr <= '0;
      req_data  <= '0;
      req_mask  <= '0;
      beat_cnt  <= '0;
      load_q    <= '0;
      rd_word   <= '0;
      tag_q     <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= take_read;
      if (sample && ((dcache_we != 4'b0000) || dcache_re)) begin
        req_waddr <= dcache_addr[31:2];
        req_data  <= dcache_din;
        req_mask  <= dcache_we;
        tag_q     <= tag_mem[in_idx];
      end
      if (take_read) begin
        rd_word  <= data_mem[{in_idx, in_off}];
        sel_load <= 1'b0;
      end
      if ((state == S_RREQ) && handshake) beat_cnt <= '0;
      if (beat_take) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == req_off) load_q <= mem.mem_resp_data;
      end
      if (beat_last) begin
        valid[req_idx] <= 1'b1;
        sel_load       <= 1'b1;
      end
    end
  end

  // array writes; state is forced to IDLE while reset is high, so nothing is written then
  always_ff @(posedge clk) begin
    if (beat_take) data_mem[{req_idx, beat_cnt}] <= mem.mem_resp_data;
    if (beat_last) tag_mem[req_idx] <= req_tag;
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b]) data_mem[{req_idx, req_off}][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/dcache_mem_side.md
# dcache_mem_side

Blocking, direct-mapped, write-through data cache that answers the core's data-memory port: `dcache_addr`, `dcache_we`, `dcache_re` and `dcache_din` in; `dcache_dout` and `stall` out.
- Reads are returned one cycle after the request.
- Misses and all stores hold the core through `stall` while the cache talks to a backing memory over a valid/ready request channel and a beat-based response channel.
- The block sits between the core and the memory arbiter. It is the responder for the core's data port.

## Interface
Parameters:
- `LINES`, default 64: number of cache lines; power of two, 4..1024. Index = `addr[3+log2(LINES):4]`, tag = `addr[31:4+log2(LINES)]`.
- `WORDS`, fixed 4: 32-bit words per line. Offset = `addr[3:2]`.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `dcache_addr`  in  32  — byte address from the core.
- `dcache_re`  in  1  — read request.
- `dcache_we`  in  4  — byte write enables; nonzero means store.
- `dcache_din`  in  32  — store data, already lane-aligned by the core.
- `dcache_dout`  out  32  — load data.
- `stall`  out  1  — core must freeze its pipeline.
- `mem_req_valid`  out  1  — backing request valid.
- `mem_req_ready`  in  1  — backing request accepted.
- `mem_req_rw`  out  1  — 1 = write, 0 = line read.
- `mem_req_addr`  out  30  — word address (`addr[31:2]`); for line reads, bits [1:0] of this field = 0.
- `mem_req_data`  out  32  — write data.
- `mem_req_mask`  out  4  — write byte mask.
- `mem_resp_valid`  in  1  — read beat valid.
- `mem_resp_data`  in  32  — read beat; 4 beats per line, word 0 first.

## Operation
Request sampling:
- A request is sampled at a rising edge only when `stall` = 0.
- Store (`dcache_we` != 0) has priority over `dcache_re`.
- If `dcache_we` = 0 and `dcache_re` = 0, no action is taken.

Arrays and state:
- Valid bits are flops, cleared by `reset`.
- Tag and data arrays are synchronous-read and are addressed by the sampled index.
- The latched request (address, data, mask, kind) is held until the block returns to IDLE.

State machine, with transitions:
- **IDLE**
  - Pending read, hit: `stall` = 0; `dcache_dout` = array word. Stay in IDLE.
  - Pending read, miss: `stall` = 1 combinationally in the same cycle. Go to RREQ.
  - Sampled store: go to WREQ.
- **WREQ**
  - Outputs: `stall` = 1, `mem_req_valid` = 1, `mem_req_rw` = 1, latched address/data/mask.
  - On the handshake edge: if the tag hits, write the masked bytes into the data array (no allocate on a miss). Go to IDLE.
- **RREQ**
  - Outputs: `stall` = 1, `mem_req_valid` = 1, `mem_req_rw` = 0, line-aligned address.
  - On handshake: beat counter := 0. Go to REFILL.
- **REFILL**
  - `stall` = 1.
  - On each `mem_resp_valid` beat: write the beat to word[counter] and increment the counter.
  - Capture the beat whose counter equals the latched offset into the load register.
  - On beat 3: set valid, write tag. Go to IDLE with `dcache_dout` = load register.

Output rules:
- `dcache_dout` selects the load register in the first IDLE cycle after a refill and the array read port otherwise.
- `dcache_dout` holds its value for stores and for cycles with no request. Its value in a miss cycle is don't-care.
- `mem_resp_valid` outside REFILL is ignored.
- Request outputs are stable while `mem_req_valid` = 1 and `mem_req_ready` = 0.

## Timing
- Read hit: request in cycle N, data on `dcache_dout` in N+1, no stall.
- Read miss: `stall` rises in N+1. The request is issued from N+2. `stall` falls in the first IDLE cycle after the 4th beat, with data valid in that same cycle.
- Store: `stall` = 1 from N+1 through the handshake cycle, so each store costs at least 1 stall cycle. The next request is sampled at the end of the following IDLE cycle, which guarantees read-after-write sees the updated array.
- Refill beats may be non-consecutive. Beats arriving in the same cycle as the RREQ handshake are not accepted; the responder starts beats no earlier than the cycle after the handshake.
- Reset, including mid-refill or mid-WREQ, takes effect immediately:
  - state = IDLE, pending flags = 0, all valids = 0;
  - `stall` = 0, `mem_req_valid` = 0, `dcache_dout` = 0;
  - the partial line is discarded. The memory side must drop in-flight beats on its own reset.
- Reset values: `stall` 0, `dcache_dout` 0, `mem_req_valid` 0, `mem_req_rw` 0, `mem_req_addr` 0, `mem_req_data` 0, `mem_req_mask` 0.

## Test plan
- **Cold read miss.** After reset, read 0x1000_0004.
  - `stall` = 1 next cycle; request rw = 0, `mem_req_addr` = 0x1000_0000>>2.
  - Beats 0xA0, 0xA1, 0xA2, 0xA3 → `dcache_dout` = 0xA1 in the cycle `stall` falls.
- **Hit after fill.** Read 0x1000_0008 → no stall; `dcache_dout` = 0xA2 one cycle later.
- **Store hit.** `dcache_we` = 0010, addr 0x1000_0009, din 0x0000_5500.
  - Write request mask 0010 and word address 0x1000_0008>>2; `stall` held while `mem_req_ready` is held low 5 cycles.
  - Then read 0x1000_0008 → 0x0000_55A2 with no stall.
- **Store miss, no allocate.** Store to 0x2000_0000 → exactly one write request; a following read of 0x2000_0000 misses and refills.
- **Conflict.** With `LINES` = 64, alternate reads of 0x1000_0004 and 0x1000_0404 → every access misses, and the correct word is returned each time.
- **Reset mid-refill.** Assert `reset` after 2 beats.
  - `stall` and `mem_req_valid` go to 0 without waiting for a clock edge.
  - A re-read of 0x1000_0004 misses and issues a fresh line read.
